// File: rtl/inst_fetch_pkg.sv
// Shared constants, types and helpers for the instruction fetch stage.
// Stall vector layout, bus widths, reset/boot vectors and the fetch FSM states.
package inst_fetch_pkg;

   localparam int STALL_WD    = 6;
   localparam int BR_WD       = 33;
   localparam int IF_TO_ID_WD = 33;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // The pre-boot PC sits one word below the reset vector so the first
   // advance lands exactly on the reset vector.
   localparam logic [31:0] BOOT_PC    = 32'hBFBF_FFFC;
   localparam logic [31:0] RESET_VEC  = 32'hBFC0_0000;
   localparam logic [31:0] PC_STEP    = 32'd4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch stage, the decode stage and the instruction SRAM.
// master = fetch stage, slave = surrounding pipeline / memory.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic [STALL_WD-1:0]    stall;
   logic [BR_WD-1:0]       br_bus;
   logic [IF_TO_ID_WD-1:0] if_to_id_bus;
   logic                   inst_sram_en;
   logic [3:0]             inst_sram_wen;
   logic [31:0]            inst_sram_addr;
   logic [31:0]            inst_sram_wdata;

   modport master (
      input  stall,
      input  br_bus,
      output if_to_id_bus,
      output inst_sram_en,
      output inst_sram_wen,
      output inst_sram_addr,
      output inst_sram_wdata
   );

   modport slave (
      output stall,
      output br_bus,
      input  if_to_id_bus,
      input  inst_sram_en,
      input  inst_sram_wen,
      input  inst_sram_addr,
      input  inst_sram_wdata
   );

endinterface

// File: rtl/inst_fetch_pc_reg.sv
// PC register, fetch enable and pending-redirect holder, sequenced by the
// BOOT/RUN/HOLD state machine.
module inst_fetch_pc_reg
   import inst_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stop,
   input  logic        br_e,
   input  logic [31:0] br_addr,
   output logic [31:0] pc,
   output logic        ce
);

   fetch_state_e state, state_nxt;
   logic [31:0]  pc_r, pc_nxt;
   logic [31:0]  pend_addr, pend_nxt;
   logic         ce_r, ce_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= BOOT;
         pc_r      <= BOOT_PC;
         ce_r      <= 1'b0;
         pend_addr <= 32'd0;
      end else begin
         state     <= state_nxt;
         pc_r      <= pc_nxt;
         ce_r      <= ce_nxt;
         pend_addr <= pend_nxt;
      end
   end

   // A redirect that arrives while stalled is parked in pend_addr; a live
   // redirect on the release cycle is newer and therefore wins.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_r;
      ce_nxt    = ce_r;
      pend_nxt  = pend_addr;

      unique case (state)
         BOOT: begin
            if (stop == NO_STOP) begin
               state_nxt = RUN;
               pc_nxt    = RESET_VEC;
               ce_nxt    = 1'b1;
            end
         end

         RUN: begin
            ce_nxt = 1'b1;
            if (stop == NO_STOP) begin
               pc_nxt = br_e ? br_addr : seq_pc(pc_r);
            end else if (br_e) begin
               pend_nxt  = br_addr;
               state_nxt = HOLD;
            end
         end

         HOLD: begin
            ce_nxt = 1'b1;
            if (stop == NO_STOP) begin
               pc_nxt    = br_e ? br_addr : pend_addr;
               state_nxt = RUN;
            end else if (br_e) begin
               pend_nxt = br_addr;
            end
         end

         default: begin
            state_nxt = BOOT;
            pc_nxt    = BOOT_PC;
            ce_nxt    = 1'b0;
         end
      endcase
   end

   assign pc = pc_r;
   assign ce = ce_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction SRAM read port from the PC
// and forwards {ce, pc} of the issued fetch to decode with no extra latency.
module inst_fetch
   import inst_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   inst_fetch_if.master bus
);

   logic        br_e;
   logic [31:0] br_addr;
   logic [31:0] pc;
   logic        ce;
   logic        unused_stall;

   assign br_e    = bus.br_bus[32];
   assign br_addr = bus.br_bus[31:0];

   // Upper stall bits steer later pipeline registers, not this stage.
   assign unused_stall = ^bus.stall[STALL_WD-1:1];

   inst_fetch_pc_reg u_pc_reg (
      .clk     (clk),
      .rst     (rst),
      .stop    (bus.stall[0]),
      .br_e    (br_e),
      .br_addr (br_addr),
      .pc      (pc),
      .ce      (ce)
   );

   assign bus.inst_sram_en    = ce;
   assign bus.inst_sram_addr  = pc;
   assign bus.inst_sram_wen   = 4'b0000;
   assign bus.inst_sram_wdata = 32'd0;
   assign bus.if_to_id_bus    = {ce, pc};

endmodule

// File: tb/tb_inst_fetch.sv
// Directed, table-driven bench for inst_fetch: per-cycle vectors plus
// hand-written sequences for boot stall and asynchronous reset mid-HOLD.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   typedef struct {
      logic [5:0]  stall;
      logic        br_e;
      logic [31:0] br_addr;
      logic [31:0] exp_addr;
      logic        exp_ce;
   } vec_t;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   vec_t vecs[$];

   inst_fetch_if bus ();

   inst_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [5:0] stall, input logic br_e, input logic [31:0] br_addr);
      bus.stall  = stall;
      bus.br_bus = {br_e, br_addr};
   endtask

   task automatic checkOutput(input string name, input logic [31:0] exp_addr, input logic exp_ce);
      tests_run++;
      if (bus.inst_sram_addr !== exp_addr) begin
         tests_failed++;
         $display("[TB] FAIL %s addr: got %h expected %h", name, bus.inst_sram_addr, exp_addr);
      end
      tests_run++;
      if (bus.inst_sram_en !== exp_ce) begin
         tests_failed++;
         $display("[TB] FAIL %s en: got %b expected %b", name, bus.inst_sram_en, exp_ce);
      end
      tests_run++;
      if (bus.if_to_id_bus !== {exp_ce, exp_addr}) begin
         tests_failed++;
         $display("[TB] FAIL %s if_to_id_bus: got %h expected %h", name, bus.if_to_id_bus, {exp_ce, exp_addr});
      end
   endtask

   task automatic checkConst(input string name);
      tests_run++;
      if (bus.inst_sram_wen !== 4'b0000 || bus.inst_sram_wdata !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL %s wen/wdata: got %h/%h expected 0/0", name, bus.inst_sram_wen, bus.inst_sram_wdata);
      end
   endtask

   task automatic stepCheck(input string name, input logic [5:0] stall, input logic br_e,
                            input logic [31:0] br_addr, input logic [31:0] exp_addr, input logic exp_ce);
      applyStimulus(stall, br_e, br_addr);
      @(posedge clk);
      #1;
      checkOutput(name, exp_addr, exp_ce);
   endtask

   task automatic addVec(input logic [5:0] s, input logic b, input logic [31:0] a,
                         input logic [31:0] ea, input logic ec);
      vec_t v;
      v.stall = s; v.br_e = b; v.br_addr = a; v.exp_addr = ea; v.exp_ce = ec;
      vecs.push_back(v);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      // Expected PC after the clock edge that samples each row's inputs.
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0000, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0004, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0008, 1'b1);
      addVec(6'b000000, 1'b1, 32'hBFC0_0100,  32'hBFC0_0100, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0104, 1'b1);
      addVec(6'b000001, 1'b1, 32'hBFC0_0200,  32'hBFC0_0104, 1'b1);
      addVec(6'b000001, 1'b0, 32'h0,          32'hBFC0_0104, 1'b1);
      addVec(6'b000001, 1'b0, 32'h0,          32'hBFC0_0104, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0200, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0204, 1'b1);
      addVec(6'b000001, 1'b1, 32'hBFC0_0300,  32'hBFC0_0204, 1'b1);
      addVec(6'b000001, 1'b1, 32'hBFC0_0400,  32'hBFC0_0204, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0400, 1'b1);
      addVec(6'b000001, 1'b1, 32'hBFC0_0300,  32'hBFC0_0400, 1'b1);
      addVec(6'b000000, 1'b1, 32'hBFC0_0500,  32'hBFC0_0500, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0504, 1'b1);
      addVec(6'b000001, 1'b0, 32'h0,          32'hBFC0_0504, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0508, 1'b1);
      addVec(6'b000000, 1'b1, 32'hBFC0_0603,  32'hBFC0_0603, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'hBFC0_0607, 1'b1);
      addVec(6'b000000, 1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 1'b1);
      addVec(6'b000000, 1'b0, 32'h0,          32'h0000_0000, 1'b1);
      addVec(6'b000010, 1'b0, 32'h0,          32'h0000_0004, 1'b1);
      addVec(6'b111110, 1'b0, 32'h0,          32'h0000_0008, 1'b1);

      rst = 1'b1;
      applyStimulus(6'b000000, 1'b1, 32'hDEAD_BEE0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", BOOT_PC, 1'b0);
      checkConst("reset");

      // Boot held by stall: no fetch until stall[0] drops.
      applyStimulus(6'b000001, 1'b0, 32'h0);
      rst = 1'b0;
      stepCheck("boot_stall0", 6'b000001, 1'b0, 32'h0, BOOT_PC, 1'b0);
      stepCheck("boot_stall1", 6'b000001, 1'b1, 32'hBFC0_0900, BOOT_PC, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].stall, vecs[i].br_e, vecs[i].br_addr);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_ce);
      end
      checkConst("run");

      // Enter HOLD with a parked redirect, then reset between edges.
      stepCheck("hold_enter", 6'b000001, 1'b1, 32'hBFC0_0700, 32'h0000_0008, 1'b1);
      #2;
      rst = 1'b1;
      applyStimulus(6'b000000, 1'b1, 32'hBFC0_0800);
      #1;
      checkOutput("async_reset", BOOT_PC, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("reset_held", BOOT_PC, 1'b0);
      applyStimulus(6'b000000, 1'b0, 32'h0);
      rst = 1'b0;
      stepCheck("post_reset0", 6'b000000, 1'b0, 32'h0, RESET_VEC, 1'b1);
      stepCheck("post_reset1", 6'b000000, 1'b0, 32'h0, 32'hBFC0_0004, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  pipeline clock; all state rises on posedge clk.
REQ-002 rst  input  1  reset, asynchronous and active-high.
REQ-003 stall  input  `StallBus  stall vector; bit 0 governs this stage (`Stop holds PC), bit 1 the IF/ID register.
REQ-004 br_bus  input  `BR_WD  {br_e, br_addr[31:0]} redirect from decode; br_e valid for one cycle.
REQ-005 if_to_id_bus  output  `IF_TO_ID_WD  {ce, pc[31:0]} of the fetch issued this cycle.
REQ-006 inst_sram_en  output  1  instruction SRAM enable.
REQ-007 inst_sram_wen  output  4  byte write enables, constant 4'b0000.
REQ-008 inst_sram_addr  output  32  fetch address.
REQ-009 inst_sram_wdata  output  32  constant 32'b0.

Function
REQ-010 State machine SHALL have states BOOT, RUN, HOLD; encoding is local.
REQ-011 BOOT: pc_r = 32'hBFBF_FFFC, ce_r = 0; next posedge with stall[0]==`NoStop -> RUN, pc_r <= 32'hBFC0_0000, ce_r <= 1.
REQ-012 RUN, stall[0]==`NoStop: pc_r <= br_e ? br_addr : pc_r + 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-013 RUN, stall[0]==`Stop, br_e==0: pc_r held, stay RUN.
REQ-014 RUN, stall[0]==`Stop, br_e==1: pend_addr <= br_addr, pc_r held, -> HOLD.
REQ-015 HOLD, stall[0]==`Stop: pc_r and pend_addr held; a further br_e overwrites pend_addr (newest redirect wins).
REQ-016 HOLD, stall[0]==`NoStop: pc_r <= br_e ? br_addr : pend_addr, -> RUN.
REQ-017 br_e and stall release in the same cycle: live br_addr SHALL take priority over pend_addr.
REQ-018 inst_sram_addr = pc_r, inst_sram_en = ce_r, combinationally; SRAM data returns one cycle later to decode.
REQ-019 if_to_id_bus = {ce_r, pc_r}; zero added latency between pc_r and the bus.
REQ-020 Delay-slot semantics: fetch at pc_r+4 already issued when br_e arrives SHALL NOT be cancelled.
REQ-021 ce_r SHALL stay 1 in RUN and HOLD; only BOOT drives 0.
REQ-022 Misaligned br_addr (bits[1:0] != 0) SHALL be fetched unchanged; exception handling lies outside this block.

Reset
REQ-023 rst asserted at any time, including mid-HOLD: state BOOT, pc_r = 32'hBFBF_FFFC, ce_r = 0, pend_addr = 0, immediately without a clock edge.
REQ-024 Reset outputs: inst_sram_en 0, inst_sram_addr 32'hBFBF_FFFC, if_to_id_bus {1'b0, 32'hBFBF_FFFC}.
REQ-025 A br_e present while rst is high SHALL be discarded.

Structure
REQ-026 `StallBus, `Stop/`NoStop, `IF_TO_ID_WD (33), `BR_WD (33) and the reset vector 32'hBFC0_0000 SHALL live in lib/defines.vh.
REQ-027 No sub-module is required; one optional leaf, pc_reg (pc_r, ce_r, pend_addr, FSM), is permitted.
REQ-028 Target size is 120-250 lines of RTL, with no latches and a single always block per register group.

Verification
REQ-029 Release rst, no stall -> addr 32'hBFC0_0000, ce 1 first cycle, then 32'hBFC0_0004, 32'hBFC0_0008.
REQ-030 Redirect in RUN: br_e=1, br_addr=32'hBFC0_0100 with pc_r=32'hBFC0_0008 -> next addr 32'hBFC0_0100, then 32'hBFC0_0104.
REQ-031 Stall with branch: stall[0]=`Stop 3 cycles, br_e pulse 32'hBFC0_0200 in cycle 1 -> addr held, HOLD; after release addr 32'hBFC0_0200.
REQ-032 Double redirect in HOLD: 32'hBFC0_0300 then 32'hBFC0_0400 during stall -> release fetches 32'hBFC0_0400.
REQ-033 Release with simultaneous br_e=32'hBFC0_0500 while pend_addr=32'hBFC0_0300 -> addr 32'hBFC0_0500.
REQ-034 Async reset mid-HOLD, asserted between edges -> outputs show REQ-024 values before the next posedge, and pend_addr is not applied after reset release.
